// File: rtl/ps_pkg.sv
// ps_pkg: shared types and helpers for the ps_if register slave
package ps_pkg;
  localparam int PS_ADDR_WIDTH = 5;
  localparam int PS_DATA_WIDTH = 32;
  typedef logic [PS_ADDR_WIDTH-1:0] ps_addr_t;
  typedef logic [PS_DATA_WIDTH-1:0] ps_data_t;
  function automatic logic ps_in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction
endpackage

// File: rtl/ps_if.sv
// ps_if: write/read request and response bundle between a master and a register slave
interface ps_if
  import ps_pkg::*;
#(
  parameter int ADDR_WIDTH = PS_ADDR_WIDTH,
  parameter int DATA_WIDTH = PS_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] bdata;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  arvalid;
  logic                  aready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;
  modport slave (
    input  waddr, wdata, wvalid, bready, raddr, arvalid, rready,
    output wready, bdata, bvalid, aready, rdata, rvalid
  );
  modport master (
    output waddr, wdata, wvalid, bready, raddr, arvalid, rready,
    input  wready, bdata, bvalid, aready, rdata, rvalid
  );
endinterface

// File: rtl/ps_resp_stage.sv
// ps_resp_stage: single-entry valid/ready output register holding one response
module ps_resp_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  can_load
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  // A load replaces the entry; otherwise a completed handshake drains it and data holds
  always_comb begin
    valid_d = load || (valid_q && !ready);
    data_d  = load ? load_data : data_q;
  end
  // Entry state, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid    = valid_q;
  assign data     = data_q;
  assign can_load = !valid_q || ready;
endmodule

// File: rtl/ps_reg_slave.sv
// ps_reg_slave: memory-mapped register bank terminating a ps_if slave port
module ps_reg_slave
  import ps_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 2**ADDR_WIDTH,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  ps_if.slave                            s,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_i
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] slot_val [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] w_cur, r_cur, b_data_in;
  logic                  w_ro, w_acc, r_acc, b_can, r_can;
  assign w_acc = s.wvalid && s.wready;
  assign r_acc = s.arvalid && s.aready;
  // Readable view of every slot: hardware input for read-only slots, flop otherwise
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      slot_val[i] = RO_MASK[i] ? ro_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = slot_val[i];
    end
  end
  // Decode both addresses; unmatched (out-of-range) addresses read as zero
  always_comb begin
    w_cur = '0;
    r_cur = '0;
    w_ro  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (s.waddr == ADDR_WIDTH'(i)) begin
        w_cur = slot_val[i];
        w_ro  = RO_MASK[i];
      end
      if (s.raddr == ADDR_WIDTH'(i)) r_cur = slot_val[i];
    end
  end
  // Write commit: strobe and update only writable in-range slots; response carries the value now readable
  always_comb begin
    b_data_in = (ps_in_range(32'(s.waddr), NUM_REGS) && !w_ro) ? s.wdata : w_cur;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_pulse_d[i] = w_acc && !RO_MASK[i] && (s.waddr == ADDR_WIDTH'(i));
      regs_d[i]     = wr_pulse_d[i] ? s.wdata : regs_q[i];
    end
  end
  // Register bank and write strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end
  assign wr_pulse_o = wr_pulse_q;
  ps_resp_stage #(.DATA_WIDTH(DATA_WIDTH)) u_b (
    .clk       (clk),
    .rst       (rst),
    .load      (w_acc),
    .load_data (b_data_in),
    .ready     (s.bready),
    .valid     (s.bvalid),
    .data      (s.bdata),
    .can_load  (b_can)
  );
  ps_resp_stage #(.DATA_WIDTH(DATA_WIDTH)) u_r (
    .clk       (clk),
    .rst       (rst),
    .load      (r_acc),
    .load_data (r_cur),
    .ready     (s.rready),
    .valid     (s.rvalid),
    .data      (s.rdata),
    .can_load  (r_can)
  );
  assign s.wready = !rst && b_can;
  assign s.aready = !rst && r_can;
endmodule

// File: tb/tb_ps_reg_slave.sv
// tb_ps_reg_slave: directed and randomized checks of ps_reg_slave against a register-map model
module tb_ps_reg_slave;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 20;
  localparam logic [NR-1:0] RO = 20'h2;
  logic clk = 1'b0;
  logic rst;
  logic [NR*DW-1:0] regs_o;
  logic [NR*DW-1:0] ro_i;
  logic [NR-1:0] wr_pulse_o;
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] m_mem [NR];
  always #5 clk = ~clk;
  ps_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ps_reg_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VALUE(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .s(bus.slave), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .ro_i(ro_i)
  );
  function automatic logic [DW-1:0] m_read(input int a);
    if (a >= NR) return '0;
    if (RO[a]) return ro_i[a*DW +: DW];
    return m_mem[a];
  endfunction
  function automatic logic [NR*DW-1:0] m_regs();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_read(i);
    return v;
  endfunction
  task automatic idle();
    bus.wvalid = 1'b0;
    bus.arvalid = 1'b0;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.wready !== 1'b0) begin n_bad++; $display("FAIL reset_wready: got %b want 0", bus.wready); end
    n_cmp++; if (bus.aready !== 1'b0) begin n_bad++; $display("FAIL reset_aready: got %b want 0", bus.aready); end
    n_cmp++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin n_bad++; $display("FAIL reset_valids: got %b want 00", {bus.bvalid, bus.rvalid}); end
    n_cmp++; if ({bus.bdata, bus.rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {bus.bdata, bus.rdata}); end
    rst = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.raddr = 5'd3;
    #1;
    n_cmp++; if (bus.aready !== 1'b1) begin n_bad++; $display("FAIL first_aready: got %b want 1", bus.aready); end
    @(negedge clk);
    bus.arvalid = 1'b0;
    n_cmp++; if (bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL first_rvalid: got %b want 1", bus.rvalid); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL first_rdata: got %h want 0", bus.rdata); end
    n_cmp++; if (wr_pulse_o !== '0) begin n_bad++; $display("FAIL first_pulse: got %h want 0", wr_pulse_o); end
    @(negedge clk);
    n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL first_rclear: got %b want 0", bus.rvalid); end
  endtask
  task automatic test_write_read();
    bus.wvalid = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (bus.wready !== 1'b1) begin n_bad++; $display("FAIL wr_wready: got %b want 1", bus.wready); end
    @(negedge clk);
    bus.wvalid = 1'b0;
    m_mem[3] = 32'hDEADBEEF;
    n_cmp++; if (bus.bvalid !== 1'b1) begin n_bad++; $display("FAIL wr_bvalid: got %b want 1", bus.bvalid); end
    n_cmp++; if (bus.bdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_bdata: got %h want deadbeef", bus.bdata); end
    n_cmp++; if (wr_pulse_o !== 20'h8) begin n_bad++; $display("FAIL wr_pulse: got %h want 00008", wr_pulse_o); end
    n_cmp++; if (regs_o !== m_regs()) begin n_bad++; $display("FAIL wr_regs: got %h want %h", regs_o, m_regs()); end
    @(negedge clk);
    n_cmp++; if (wr_pulse_o !== '0) begin n_bad++; $display("FAIL wr_pulse_once: got %h want 0", wr_pulse_o); end
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL wr_bclear: got %b want 0", bus.bvalid); end
    bus.arvalid = 1'b1; bus.raddr = 5'd3;
    @(negedge clk);
    bus.arvalid = 1'b0;
    n_cmp++; if (bus.rdata !== 32'hDEADBEEF || bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL wr_readback: got %b/%h want 1/deadbeef", bus.rvalid, bus.rdata); end
    @(negedge clk);
  endtask
  task automatic test_backpressure();
    logic [DW-1:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    bus.wvalid = 1'b1; bus.waddr = 5'd5; bus.wdata = d1; bus.bready = 1'b0;
    @(negedge clk);
    m_mem[5] = d1;
    bus.waddr = 5'd6; bus.wdata = d2;
    #1;
    n_cmp++; if (bus.wready !== 1'b0) begin n_bad++; $display("FAIL bp_wready_low: got %b want 0", bus.wready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.bvalid !== 1'b1 || bus.bdata !== d1) begin n_bad++; $display("FAIL bp_hold%0d: got %b/%h want 1/%h", k, bus.bvalid, bus.bdata, d1); end
      n_cmp++; if (regs_o !== m_regs()) begin n_bad++; $display("FAIL bp_regs%0d: got %h want %h", k, regs_o, m_regs()); end
    end
    bus.bready = 1'b1;
    #1;
    n_cmp++; if (bus.wready !== 1'b1) begin n_bad++; $display("FAIL bp_wready_rise: got %b want 1", bus.wready); end
    @(negedge clk);
    bus.wvalid = 1'b0;
    m_mem[6] = d2;
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bdata !== d2) begin n_bad++; $display("FAIL bp_next: got %b/%h want 1/%h", bus.bvalid, bus.bdata, d2); end
    n_cmp++; if (wr_pulse_o !== 20'h40) begin n_bad++; $display("FAIL bp_pulse: got %h want 00040", wr_pulse_o); end
    @(negedge clk);
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL bp_bclear: got %b want 0", bus.bvalid); end
  endtask
  task automatic test_read_only();
    bus.wvalid = 1'b1; bus.waddr = 5'd1; bus.wdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus.wvalid = 1'b0;
    n_cmp++; if (wr_pulse_o !== '0) begin n_bad++; $display("FAIL ro_pulse: got %h want 0", wr_pulse_o); end
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bdata !== 32'h12345678) begin n_bad++; $display("FAIL ro_bdata: got %b/%h want 1/12345678", bus.bvalid, bus.bdata); end
    bus.arvalid = 1'b1; bus.raddr = 5'd1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h12345678) begin n_bad++; $display("FAIL ro_rdata: got %b/%h want 1/12345678", bus.rvalid, bus.rdata); end
    @(negedge clk);
  endtask
  task automatic test_out_of_range();
    bus.wvalid = 1'b1; bus.waddr = 5'd25; bus.wdata = $urandom | 32'h1;
    bus.arvalid = 1'b1; bus.raddr = 5'd25;
    @(negedge clk);
    idle();
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bdata !== 32'h0) begin n_bad++; $display("FAIL oor_bdata: got %b/%h want 1/0", bus.bvalid, bus.bdata); end
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin n_bad++; $display("FAIL oor_rdata: got %b/%h want 1/0", bus.rvalid, bus.rdata); end
    n_cmp++; if (wr_pulse_o !== '0) begin n_bad++; $display("FAIL oor_pulse: got %h want 0", wr_pulse_o); end
    n_cmp++; if (regs_o !== m_regs()) begin n_bad++; $display("FAIL oor_regs: got %h want %h", regs_o, m_regs()); end
    @(negedge clk);
  endtask
  task automatic test_same_cycle();
    bus.wvalid = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hA5;
    bus.arvalid = 1'b1; bus.raddr = 5'd7;
    @(negedge clk);
    bus.wvalid = 1'b0;
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin n_bad++; $display("FAIL same_old: got %b/%h want 1/0", bus.rvalid, bus.rdata); end
    n_cmp++; if (bus.bvalid !== 1'b1 || bus.bdata !== 32'hA5) begin n_bad++; $display("FAIL same_bdata: got %b/%h want 1/a5", bus.bvalid, bus.bdata); end
    m_mem[7] = 32'hA5;
    @(negedge clk);
    bus.arvalid = 1'b0;
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA5) begin n_bad++; $display("FAIL same_new: got %b/%h want 1/a5", bus.rvalid, bus.rdata); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    logic [DW-1:0] v [4];
    for (int k = 0; k < 4; k++) v[k] = $urandom;
    bus.wvalid = 1'b1; bus.waddr = 5'd8; bus.wdata = v[0];
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      m_mem[7+k] = v[k-1];
      n_cmp++; if (bus.bvalid !== 1'b1 || bus.bdata !== v[k-1]) begin n_bad++; $display("FAIL b2b_resp%0d: got %b/%h want 1/%h", k, bus.bvalid, bus.bdata, v[k-1]); end
      if (k < 4) begin
        bus.waddr = AW'(8 + k); bus.wdata = v[k];
        #1;
        n_cmp++; if (bus.wready !== 1'b1) begin n_bad++; $display("FAIL b2b_wready%0d: got %b want 1", k, bus.wready); end
      end else bus.wvalid = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (bus.bvalid !== 1'b0 || regs_o !== m_regs()) begin n_bad++; $display("FAIL b2b_end: got %b/%h want 0/%h", bus.bvalid, regs_o, m_regs()); end
  endtask
  task automatic test_random();
    logic m_bv, m_rv, w_acc, r_acc, e_wr, e_ar;
    logic [DW-1:0] m_bd, m_rd;
    logic [NR-1:0] m_pulse;
    int wa, ra;
    int bad0;
    m_bv = 1'b0; m_rv = 1'b0; m_bd = '0; m_rd = '0; m_pulse = '0;
    bad0 = n_bad;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (n_bad - bad0 < 10) begin
        n_cmp++; if (bus.bvalid !== m_bv || (m_bv && bus.bdata !== m_bd)) begin n_bad++; $display("FAIL rnd_b@%0d: got %b/%h want %b/%h", cyc, bus.bvalid, bus.bdata, m_bv, m_bd); end
        n_cmp++; if (bus.rvalid !== m_rv || (m_rv && bus.rdata !== m_rd)) begin n_bad++; $display("FAIL rnd_r@%0d: got %b/%h want %b/%h", cyc, bus.rvalid, bus.rdata, m_rv, m_rd); end
        n_cmp++; if (wr_pulse_o !== m_pulse) begin n_bad++; $display("FAIL rnd_pulse@%0d: got %h want %h", cyc, wr_pulse_o, m_pulse); end
        n_cmp++; if (regs_o !== m_regs()) begin n_bad++; $display("FAIL rnd_regs@%0d: mismatch in register map", cyc); end
      end
      bus.wvalid = 1'($urandom_range(0, 1));
      bus.waddr = AW'($urandom_range(0, 31));
      bus.wdata = $urandom;
      bus.arvalid = 1'($urandom_range(0, 1));
      bus.raddr = AW'($urandom_range(0, 31));
      bus.bready = ($urandom_range(0, 3) != 0);
      bus.rready = ($urandom_range(0, 3) != 0);
      ro_i[DW +: DW] = $urandom;
      #1;
      e_wr = !m_bv || bus.bready;
      e_ar = !m_rv || bus.rready;
      if (n_bad - bad0 < 10) begin
        n_cmp++; if (bus.wready !== e_wr || bus.aready !== e_ar) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", cyc, bus.wready, bus.aready, e_wr, e_ar); end
      end
      w_acc = bus.wvalid && e_wr;
      r_acc = bus.arvalid && e_ar;
      wa = int'(bus.waddr);
      ra = int'(bus.raddr);
      if (r_acc) begin m_rv = 1'b1; m_rd = m_read(ra); end
      else if (bus.rready) m_rv = 1'b0;
      m_pulse = '0;
      if (w_acc) begin
        if (wa < NR && !RO[wa]) begin m_mem[wa] = bus.wdata; m_pulse[wa] = 1'b1; end
        m_bv = 1'b1; m_bd = m_read(wa);
      end else if (bus.bready) m_bv = 1'b0;
    end
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    bus.arvalid = 1'b1; bus.raddr = 5'd3; bus.rready = 1'b0;
    bus.wvalid = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h0BAD_F00D; bus.bready = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0; bus.wvalid = 1'b0;
    m_mem[4] = 32'h0BAD_F00D;
    n_cmp++; if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got %b%b want 11", bus.rvalid, bus.bvalid); end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    n_cmp++; if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL mid_drop: got %b%b want 00", bus.rvalid, bus.bvalid); end
    n_cmp++; if (regs_o !== m_regs()) begin n_bad++; $display("FAIL mid_regs: got %h want %h", regs_o, m_regs()); end
    n_cmp++; if (bus.wready !== 1'b0 || bus.aready !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b%b want 00", bus.wready, bus.aready); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL mid_noreplay: got %b%b want 00", bus.rvalid, bus.bvalid); end
  endtask
  initial begin
    for (int i = 0; i < NR; i++) ro_i[i*DW +: DW] = $urandom;
    ro_i[DW +: DW] = 32'h12345678;
    bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_read_only();
    test_out_of_range();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps_reg_slave.md
Name: ps_reg_slave

Overview:
- Responder end of the ps_if protocol: a memory-mapped register bank that terminates one ps_if.slave modport.
- Accepts writes and returns a write response with the committed value.
- Accepts read addresses and returns read data through a registered, back-pressurable response stage.
- Exposes register contents and per-register write strobes to hardware; read-only slots are fed from hardware inputs.

Parameters:
- ADDR_WIDTH, 5, width of waddr/raddr.
- DATA_WIDTH, 32, register and data width.
- NUM_REGS, 2**ADDR_WIDTH, implemented registers at addresses 0..NUM_REGS-1.
- RO_MASK, '0 (NUM_REGS bits), bit i set means register i is read-only and sourced from ro_i.
- RESET_VALUE, '0 (DATA_WIDTH), reset value of every writable register.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s  ps_if.slave  -  bus port; signals below are its members.
- s.waddr, s.wdata, s.wvalid  input  ADDR_WIDTH/DATA_WIDTH/1  write request.
- s.wready  output  1  write request accepted this cycle if wvalid.
- s.bdata, s.bvalid  output  DATA_WIDTH/1  write response.
- s.bready  input  1  master accepts the write response.
- s.raddr, s.arvalid  input  ADDR_WIDTH/1  read request.
- s.aready  output  1  read request accepted this cycle if arvalid.
- s.rdata, s.rvalid  output  DATA_WIDTH/1  read response.
- s.rready  input  1  master accepts the read response.
- regs_o  output  NUM_REGS*DATA_WIDTH  flattened register contents; slot i at [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o  output  NUM_REGS  one-cycle strobe, bit i, when register i is written.
- ro_i  input  NUM_REGS*DATA_WIDTH  values returned for RO_MASK slots; other slots are ignored.

Behaviour:
- Reset (async assert, sync release):
  - Writable registers load RESET_VALUE.
  - bvalid, rvalid, bdata, rdata and wr_pulse_o are 0.
  - wready and aready are held 0 while rst is high.
- Write accept:
  - wready = !rst && (!bvalid || bready), combinational.
  - Accept means wvalid && wready.
- On accept at cycle N, the following take effect at edge N+1:
  - reg[waddr] <= wdata, only if waddr < NUM_REGS and RO_MASK[waddr] == 0.
  - wr_pulse_o[waddr] = 1 for exactly one cycle on an effective write only.
  - bvalid = 1, with bdata = value now readable at waddr:
    - wdata for a writable register;
    - ro_i slot sampled at N for an RO register;
    - 0 for an out-of-range address.
- Write response:
  - bvalid and bdata are held stable until bready.
  - bvalid && bready with no new accept clears bvalid.
  - With a simultaneous new accept, bvalid stays 1 and bdata updates.
  - Sustained throughput is one write per cycle when bready = 1.
- Read accept:
  - aready = !rst && (!rvalid || rready); accept means arvalid && aready.
  - rdata at N+1 is reg[raddr] as of cycle N (pre-write), ro_i slot for RO registers, 0 if out of range.
  - Latency is 1 cycle.
  - Hold, clear and back-to-back rules are identical to the write response.
- Same-cycle write and read to one address: the read returns the old value; the next read returns the new value.
- Write and read channels are independent and may accept in the same cycle.
- Reset mid-transaction drops any pending bvalid/rvalid immediately (async); no response is replayed.
- Output stability rule: bdata/rdata never change while valid && !ready.

Decomposition:
- Package ps_pkg:
  - ps_addr_t / ps_data_t typedefs parameterised by ADDR_WIDTH/DATA_WIDTH defaults.
  - function ps_in_range(addr, num_regs).
- Sub-module ps_resp_stage:
  - Generic single-entry valid/ready output register (DATA_WIDTH param).
  - Inputs: load, load_data, ready. Outputs: valid, data, and can_load = !valid || ready.
  - Instantiated twice, once for the B channel and once for the R channel; top-level wready/aready are can_load gated by !rst.

Test Plan:
- Reset then read addr 3 with rready=1 → aready=1, rvalid at the next cycle, rdata=RESET_VALUE, all wr_pulse_o=0.
- Write addr 3 = 0xDEADBEEF, bready=1 → bvalid next cycle with bdata=0xDEADBEEF, wr_pulse_o[3] one cycle, then read 3 returns 0xDEADBEEF.
- Hold bready=0 after a write:
  - wready drops to 0 and bvalid/bdata stay stable for 5 cycles.
  - Raise bready with wvalid asserted → a new write is accepted in that same cycle.
- RO_MASK[1]=1, ro_i slot1=0x12345678, write addr 1 = 0xFFFFFFFF → no wr_pulse, bdata=0x12345678, read 1 returns 0x12345678.
- NUM_REGS=20 with a write/read at addr 25 → response given, bdata=rdata=0, no register changes.
- Same-cycle write addr 7=0xA5 and read addr 7 (reg holds 0x00) → rdata=0x00; a following read gives 0xA5.
- Assert rst while rvalid=1, rready=0 → rvalid=0 immediately and all registers are RESET_VALUE.
